demux_stream: RTL and testbench
===============================

// Module: demux_stream
// PURPOSE
//  Registered 1-to-N stream demultiplexer: the inverse of the 2:1 select path.
//  - One valid/ready input stream carries a destination select.
//  - Each beat is steered into one of N_OUT per-output holding slots.
//  - Each slot presents its beat on its own valid/ready output.
//  - Placed between a shared producer and independent consumers.
//  - Out-of-range selects are consumed, dropped and counted.
// PARAMETERS
//  DW     8                          data width per beat
//  N_OUT  4                          number of output channels, >=2
//  SEL_W  $clog2(N_OUT)              select width (derived, localparam)
//  CNT_W  8                          width of saturating drop counter
// PORTS
//  clk        input   1            single clock, rising edge
//  rst_n      input   1            asynchronous, active-low reset
//  in_data    input   DW           input beat payload
//  in_sel     input   SEL_W        destination channel index
//  in_valid   input   1            input beat valid
//  in_ready   output  1            block accepts beat this cycle
//  out_data   output  N_OUT*DW     slot payloads, channel k at [k*DW +: DW]
//  out_valid  output  N_OUT        per-channel beat valid
//  out_ready  input   N_OUT        per-channel consumer ready
//  drop_cnt   output  CNT_W        saturating count of dropped beats
//  sel_err    output  1            1-cycle pulse, cycle after a drop
// BEHAVIOUR
//  Interface:
//  - One clock. Reset is asynchronous and active-low.
//  - On rst_n low, immediately and independent of clk:
//    out_valid=0, out_data=0, drop_cnt=0, sel_err=0.
//  - Reset mid-operation discards all held beats; no partial delivery.
//  Acceptance:
//  - Define acc = in_valid & in_ready.
//  - in_ready is combinational on in_sel, out_valid and out_ready:
//    - in_sel < N_OUT: in_ready = !out_valid[in_sel] | out_ready[in_sel].
//    - in_sel >= N_OUT: in_ready = 1. The beat is consumed and dropped.
//  - in_ready may be high with in_valid low. The producer must hold
//    in_data/in_sel stable while in_valid & !in_ready.
//  Slot k:
//  - State EMPTY/FULL, encoded by out_valid[k].
//  - EMPTY -> FULL on acc & in_sel==k. out_data[k] loads in_data at that edge.
//  - FULL & out_ready[k] & !(acc & in_sel==k) -> EMPTY. out_data[k] holds
//    its last value; no clearing is required.
//  - FULL & out_ready[k] & acc & in_sel==k -> stays FULL and loads the new
//    beat. This gives full throughput, 1 beat/cycle per channel.
//  - FULL & !out_ready[k] -> holds. out_data[k] must stay stable while
//    out_valid[k] is high.
//  Timing and ordering:
//  - Latency is exactly 1 cycle: a beat accepted at edge t has out_valid
//    high from edge t onward (visible in cycle t+1).
//  - A stalled channel blocks only beats addressed to it; other channels
//    continue (no head-of-line blocking across different in_sel).
//  - Per-channel order is preserved. Cross-channel order is not defined.
//  Drop counting:
//  - Drop = acc & in_sel>=N_OUT.
//  - On a drop, drop_cnt increments, saturating at 2**CNT_W-1 without wrap.
//  - sel_err=1 for exactly the following cycle.
//  - Back-to-back drops keep sel_err high on consecutive cycles.
//  - When N_OUT is a power of 2 the drop path is unreachable; it must
//    still synthesise.
// STRUCTURE
//  - demux_pkg: ds_slot_state_e {DS_EMPTY, DS_FULL}, and a function
//    ds_sel_w(n) returning max(1,$clog2(n)).
//  - Sub-module demux_slot (DW): one holding register plus valid flag and
//    load/unload logic. Instantiated N_OUT times via generate.
//  - Top level holds in_ready select logic, drop detect, counter and sel_err.
// TESTING
//  1 Reset: rst_n=0 mid-cycle with slots full -> out_valid=0, drop_cnt=0,
//    sel_err=0 before next clk edge.
//  2 Single beat: in_data=8'hA5, in_sel=2, 1 cycle, out_ready=4'hF ->
//    out_valid=4'b0100 for 1 cycle, out_data[2]=8'hA5.
//  3 Backpressure: beat 8'h11 to ch1, out_ready[1]=0, then 8'h22 to ch1 ->
//    in_ready=0; raise out_ready[1] -> 8'h11 delivered, 8'h22 loaded same edge.
//  4 No HOL: ch0 full and stalled; stream 8'h30..8'h33 to ch3 with
//    out_ready[3]=1 -> 4 beats in 4 cycles, ch0 keeps its value.
//  5 Drop (N_OUT=3): in_sel=3, in_data=8'hEE -> in_ready=1, no out_valid,
//    sel_err pulse, drop_cnt=1.
//  6 Saturation (N_OUT=3): 300 consecutive drops -> drop_cnt=8'hFF,
//    sel_err high for 300 cycles.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and helpers for the registered 1-to-N stream demultiplexer.
package demux_pkg;

  typedef enum logic {
    DS_EMPTY = 1'b0,
    DS_FULL  = 1'b1
  } ds_slot_state_e;

  // Select width for n channels, never narrower than one bit.
  function automatic int ds_sel_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// Purpose: one per-channel holding register with its valid flag.
// Latency: beat loaded at edge t is presented from edge t onward.
// Backpressure: holds beat and data stable while out_ready is low.
module demux_slot
  import demux_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] in_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  ds_slot_state_e state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DS_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // A load on a draining slot keeps it full: that is the 1 beat/cycle path.
  always_comb begin
    state_nxt = state;
    case (state)
      DS_EMPTY: if (load) state_nxt = DS_FULL;
      DS_FULL:  if (out_ready && !load) state_nxt = DS_EMPTY;
      default:  state_nxt = DS_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (load) begin
      out_data <= in_data;
    end
  end

  assign out_valid = (state == DS_FULL);

endmodule

// File: rtl/demux_stream.sv
// Purpose: steer each input beat into one of N_OUT holding slots; drop and count bad selects.
// Latency: 1 cycle from acceptance to out_valid.
// Backpressure: in_ready follows only the addressed slot; out-of-range selects always accepted.
module demux_stream
  import demux_pkg::*;
#(
  parameter  int DW    = 8,
  parameter  int N_OUT = 4,
  parameter  int CNT_W = 8,
  localparam int SEL_W = ds_sel_w(N_OUT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DW-1:0]       in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [N_OUT*DW-1:0] out_data,
  output logic [N_OUT-1:0]    out_valid,
  input  logic [N_OUT-1:0]    out_ready,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic                sel_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_OUT-1:0] slot_vld;
  logic [N_OUT-1:0] load;
  logic             sel_ok;
  logic             acc;
  logic             drop;

  assign sel_ok = (int'(in_sel) < N_OUT);

  // Loop compare instead of indexing keeps out-of-range selects safe.
  always_comb begin
    in_ready = 1'b1;
    for (int k = 0; k < N_OUT; k++) begin
      if (int'(in_sel) == k) in_ready = !slot_vld[k] || out_ready[k];
    end
  end

  assign acc  = in_valid && in_ready;
  assign drop = acc && !sel_ok;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    assign load[k] = acc && (int'(in_sel) == k);

    demux_slot #(.DW(DW)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .in_data   (in_data),
      .out_ready (out_ready[k]),
      .out_valid (slot_vld[k]),
      .out_data  (out_data[k*DW +: DW])
    );
  end

  assign out_valid = slot_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      sel_err  <= 1'b0;
    end else begin
      sel_err <= drop;
      if (drop && (drop_cnt != CNT_MAX)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_stream.sv
// Randomised and directed bench for demux_stream (3 channels, so select 3 is out of range).
module tb_demux_stream;

  localparam int DW = 8;
  localparam int N  = 3;
  localparam int CW = 8;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   in_data;
  logic [SW-1:0]   in_sel;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [CW-1:0]   drop_cnt;
  logic            sel_err;

  demux_stream #(.DW(DW), .N_OUT(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  // Reference: each channel is a FIFO of accepted, undelivered beats.
  logic [DW-1:0] q [N][$];
  int            m_drops;
  bit            m_err;
  bit            held;
  int            n_vec;
  int            n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    int s = int'(in_sel);
    if (s >= N) return 1'b1;
    return (q[s].size() == 0) || out_ready[s];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) q[k].delete();
    m_drops = 0;
    m_err   = 1'b0;
    held    = 1'b0;
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  task automatic step();
    bit rdy, acc;
    int s;
    @(negedge clk);
    s   = int'(in_sel);
    rdy = exp_ready();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("vld%0d", k), 32'(out_valid[k]), 32'(q[k].size() != 0));
      if (q[k].size() != 0) chk($sformatf("dat%0d", k), 32'(out_data[k*DW +: DW]), 32'(q[k][0]));
    end
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("drop_cnt", 32'(drop_cnt), (m_drops > 255) ? 32'd255 : 32'(m_drops));
    chk("sel_err", 32'(sel_err), 32'(m_err));
    acc  = in_valid && rdy;
    held = in_valid && !rdy;
    @(posedge clk);
    for (int k = 0; k < N; k++)
      if (out_ready[k] && q[k].size() != 0) void'(q[k].pop_front());
    m_err = acc && (s >= N);
    if (acc && s < N) q[s].push_back(in_data);
    if (m_err) m_drops++;
    #1;
  endtask

  task automatic drive(input bit v, input int s, input logic [DW-1:0] d, input logic [N-1:0] r);
    in_valid  = v;
    in_sel    = SW'(s);
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_clear();
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 3'b000);
    #12;
    chk("rst_vld", 32'(out_valid), 32'h0);
    chk("rst_dat", 32'(out_data), 32'h0);
    chk("rst_cnt", 32'(drop_cnt), 32'h0);
    chk("rst_err", 32'(sel_err), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Single beat to channel 2, one-cycle visibility.
    drive(1, 2, 8'hA5, 3'b111);
    step();
    drive(0, 0, 8'h00, 3'b111);
    chk("t2_vld", 32'(out_valid), 32'b100);
    chk("t2_dat", 32'(out_data[2*DW +: DW]), 32'hA5);
    step();
    chk("t2_gone", 32'(out_valid), 32'b000);

    // Backpressure on channel 1, then simultaneous deliver and reload.
    drive(1, 1, 8'h11, 3'b101);
    step();
    drive(1, 1, 8'h22, 3'b101);
    #1 chk("t3_rdy", 32'(in_ready), 32'h0);
    step();
    step();
    drive(1, 1, 8'h22, 3'b111);
    step();
    drive(0, 0, 8'h00, 3'b101);
    chk("t3_vld", 32'(out_valid[1]), 32'h1);
    chk("t3_dat", 32'(out_data[DW +: DW]), 32'h22);
    step();
    drive(0, 0, 8'h00, 3'b111);
    step();

    // Channel 0 stalled, channel 2 keeps streaming.
    drive(1, 0, 8'h5A, 3'b100);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 2, 8'(8'h30 + i), 3'b100);
      #1 chk("t4_rdy", 32'(in_ready), 32'h1);
      step();
    end
    drive(0, 0, 8'h00, 3'b100);
    chk("t4_ch0", 32'(out_data[0 +: DW]), 32'h5A);
    chk("t4_ch2", 32'(out_data[2*DW +: DW]), 32'h33);
    drive(0, 0, 8'h00, 3'b111);
    step();
    step();

    // Single drop.
    drive(1, 3, 8'hEE, 3'b111);
    step();
    drive(0, 0, 8'h00, 3'b111);
    chk("t5_vld", 32'(out_valid), 32'h0);
    chk("t5_err", 32'(sel_err), 32'h1);
    chk("t5_cnt", 32'(drop_cnt), 32'h1);
    step();
    chk("t5_err_off", 32'(sel_err), 32'h0);

    // 300 back-to-back drops saturate the counter.
    drive(1, 3, 8'hEE, 3'b111);
    for (int i = 0; i < 300; i++) step();
    drive(0, 0, 8'h00, 3'b111);
    chk("t6_cnt", 32'(drop_cnt), 32'hFF);
    chk("t6_err", 32'(sel_err), 32'h1);
    step();

    // Asynchronous reset with slots full, checked before the next edge.
    drive(1, 0, 8'h77, 3'b000);
    step();
    drive(1, 1, 8'h88, 3'b000);
    step();
    drive(0, 0, 8'h00, 3'b000);
    #3 rst_n = 1'b0;
    #1;
    chk("t1_vld", 32'(out_valid), 32'h0);
    chk("t1_cnt", 32'(drop_cnt), 32'h0);
    chk("t1_err", 32'(sel_err), 32'h0);
    model_clear();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic with bad selects mixed in; hold rule honoured.
    for (int i = 0; i < 3000; i++) begin
      if (!held) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = SW'($urandom_range(0, 3));
        in_data  = 8'($urandom);
      end
      for (int k = 0; k < N; k++) out_ready[k] = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
